// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Loader FSM state encoding and byte-lane geometry, shared with
//               the instruction-memory and fetch blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int c_lane_count = 4;
    localparam int c_byte_width = 8;
    localparam int c_lane_bits  = $clog2(c_lane_count);
    localparam int c_word_width = c_lane_count * c_byte_width;

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_byte_packer
// Description : Assembles four bytes into a little-endian instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [c_byte_width-1:0] byte_in,
    output logic [c_word_width-1:0] word,
    output logic                    last_lane
);

    logic [c_lane_bits-1:0]  r_lane;
    logic [c_word_width-1:0] r_word;

    // Lane counter wraps naturally after the last lane
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (load) begin
            r_word[r_lane*c_byte_width +: c_byte_width] <= byte_in;
            r_lane <= r_lane + c_lane_bits'(1);
        end
    end

    assign word      = r_word;
    assign last_lane = (r_lane == c_lane_bits'(c_lane_count - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams program bytes into instruction memory word by word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INS_WIDTH  = 32,
    parameter int INS_DEPTH  = 64,
    parameter int ADDR_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_DEPTH-1:0] load_len,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_DEPTH-1:0] wr_addr,
    output logic [INS_WIDTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_DEPTH-1:0] c_depth = ADDR_DEPTH'(INS_DEPTH);
    localparam logic [ADDR_DEPTH-1:0] c_one   = ADDR_DEPTH'(1);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_DEPTH-1:0]   r_word_idx;
    logic [ADDR_DEPTH-1:0]   r_len;
    logic [ADDR_DEPTH-1:0]   r_addr_q;
    logic [INS_WIDTH-1:0]    r_data_q;
    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_last_write;
    logic                    w_last_lane;
    logic                    w_clear;
    logic                    w_in_write;
    logic [c_word_width-1:0] w_word;

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_xfer       = 1'b0;
        w_last_write = ((r_word_idx + c_one) == r_len);
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        if (load_len == '0) begin
                            w_next = ST_DONE;
                        end else if (load_len > c_depth) begin
                            w_next = ST_ERR;
                        end else begin
                            w_next   = ST_RECV;
                            w_accept = 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (byte_valid) begin
                        w_xfer = 1'b1;
                        if (w_last_lane) begin
                            w_next = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: w_next = w_last_write ? ST_DONE : ST_RECV;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Abort also flushes any partially assembled word
    assign w_clear = w_accept | abort;

    imem_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .load      (w_xfer),
        .byte_in   (byte_in),
        .word      (w_word),
        .last_lane (w_last_lane)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_len      <= '0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_word_idx <= '0;
                r_len      <= load_len;
            end else if (w_in_write && !abort) begin
                r_addr_q <= r_word_idx;
                r_data_q <= w_word;
                // Index stays at the last address so it never reaches INS_DEPTH
                if (!w_last_write) begin
                    r_word_idx <= r_word_idx + c_one;
                end
            end
        end
    end

    assign w_in_write = (r_state == ST_WRITE);
    assign byte_ready = (r_state == ST_RECV);
    assign wr_en      = w_in_write && !abort;
    assign wr_addr    = w_in_write ? r_word_idx : r_addr_q;
    assign wr_data    = w_in_write ? w_word : r_data_q;
    assign busy       = (r_state == ST_RECV) || w_in_write;
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [63:0] load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .INS_WIDTH  (32),
        .INS_DEPTH  (64),
        .ADDR_DEPTH (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [63:0] len);
        load_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (byte_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_byte_timeout: byte_ready=%b want 1", byte_ready);
        end
        step();
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        load_len = '0; byte_in = '0; byte_valid = 1'b0;
        step(); step();
        total_cnt++;
        if ({byte_ready, wr_en, busy, done, error} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {byte_ready, wr_en, busy, done, error});
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 64'd0 || wr_data !== 32'd0)
            $display("FAIL reset_bus: addr=%0h data=%0h want 0 0", wr_addr, wr_data);
        else pass_cnt++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd1);
        total_cnt++;
        if (busy !== 1'b1 || byte_ready !== 1'b1)
            $display("FAIL single_recv: busy=%b ready=%b want 1 1", busy, byte_ready);
        else pass_cnt++;
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h01);
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 64'd0 || wr_data !== 32'h01500513)
            $display("FAIL single_write: en=%b addr=%0h data=%h want 1 0 01500513", wr_en, wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL single_done: en=%b done=%b busy=%b want 0 1 0", wr_en, done, busy);
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 64'd0 || wr_data !== 32'h01500513)
            $display("FAIL single_hold: addr=%0h data=%h want 0 01500513", wr_addr, wr_data);
        else pass_cnt++;
        total_cnt++;
        if (wa_q.size() !== 1)
            $display("FAIL single_count: writes=%0d want 1", wa_q.size());
        else pass_cnt++;
    endtask

    task automatic test_toggle_valid();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd2);
        send_byte(8'h13); step(); send_byte(8'h01); step();
        send_byte(8'h20); step(); send_byte(8'h00);
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 64'd0 || wr_data !== 32'h00200113)
            $display("FAIL toggle_w0: en=%b addr=%0h data=%h want 1 0 00200113", wr_en, wr_addr, wr_data);
        else pass_cnt++;
        step();
        send_byte(8'h93); step(); send_byte(8'h01); step();
        send_byte(8'hC0); step(); send_byte(8'h00);
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 64'd1 || wr_data !== 32'h00C00193 || done !== 1'b0)
            $display("FAIL toggle_w1: en=%b addr=%0h data=%h done=%b want 1 1 00c00193 0",
                     wr_en, wr_addr, wr_data, done);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b1 || wa_q.size() !== 2)
            $display("FAIL toggle_done: done=%b writes=%0d want 1 2", done, wa_q.size());
        else pass_cnt++;
    endtask

    task automatic test_len_bounds();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd65);
        total_cnt++;
        if (error !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL len65_err: error=%b done=%b ready=%b want 1 0 0", error, done, byte_ready);
        else pass_cnt++;
        step(); step(); step();
        total_cnt++;
        if (error !== 1'b1 || byte_ready !== 1'b0)
            $display("FAIL len65_hold: error=%b ready=%b want 1 0", error, byte_ready);
        else pass_cnt++;
        pulse_start(64'd0);
        total_cnt++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0)
            $display("FAIL len0_done: done=%b error=%b busy=%b want 1 0 0", done, error, busy);
        else pass_cnt++;
        pulse_start(64'd64);
        total_cnt++;
        if (busy !== 1'b1 || error !== 1'b0)
            $display("FAIL len64_accept: busy=%b error=%b want 1 0", busy, error);
        else pass_cnt++;
        abort = 1'b1; step(); abort = 1'b0;
        total_cnt++;
        if (wa_q.size() !== 0)
            $display("FAIL len_bounds_writes: writes=%0d want 0", wa_q.size());
        else pass_cnt++;
    endtask

    task automatic test_abort_partial();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd2);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2);
        abort = 1'b1; step(); abort = 1'b0;
        total_cnt++;
        if ({busy, done, error, byte_ready} !== 4'b0)
            $display("FAIL abort_idle: flags=%b want 0000", {busy, done, error, byte_ready});
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if (wa_q.size() !== 1 || wa_q[0] !== 64'd0 || wd_q[0] !== 32'hA4A3A2A1)
            $display("FAIL abort_writes: writes=%0d want 1 at addr 0 data a4a3a2a1", wa_q.size());
        else pass_cnt++;
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        step();
        total_cnt++;
        if (wa_q.size() !== 1 || wa_q[0] !== 64'd0 || wd_q[0] !== 32'h44332211 || done !== 1'b1)
            $display("FAIL abort_restart: writes=%0d done=%b want 1 write of 44332211 at 0, done 1",
                     wa_q.size(), done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd1);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({byte_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== 64'd0 || wr_data !== 32'd0)
            $display("FAIL rstmid_async: flags=%b addr=%0h data=%h want 00000 0 0",
                     {byte_ready, wr_en, busy, done, error}, wr_addr, wr_data);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        byte_in = 8'hC4; byte_valid = 1'b1;
        step(); step(); step();
        byte_valid = 1'b0;
        total_cnt++;
        if (wa_q.size() !== 0 || {byte_ready, busy, done, error} !== 4'b0)
            $display("FAIL rstmid_idle: writes=%0d flags=%b want 0 0000",
                     wa_q.size(), {byte_ready, busy, done, error});
        else pass_cnt++;
        pulse_start(64'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        step();
        total_cnt++;
        if (wa_q.size() !== 1 || wd_q[0] !== 32'hDDCCBBAA || wa_q[0] !== 64'd0)
            $display("FAIL rstmid_reload: writes=%0d want 1 write of ddccbbaa at 0", wa_q.size());
        else pass_cnt++;
    endtask

    task automatic test_busy_start_abort();
        wa_q.delete(); wd_q.delete();
        pulse_start(64'd2);
        send_byte(8'h11); send_byte(8'h22);
        pulse_start(64'd1);
        send_byte(8'h33); send_byte(8'h44);
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 64'd0 || wr_data !== 32'h44332211)
            $display("FAIL busystart_write: en=%b addr=%0h data=%h want 1 0 44332211", wr_en, wr_addr, wr_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL busystart_len: busy=%b done=%b want 1 0", busy, done);
        else pass_cnt++;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        byte_in = 8'h88; byte_valid = 1'b1; abort = 1'b1;
        step();
        byte_valid = 1'b0; abort = 1'b0;
        total_cnt++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL abort4th_idle: en=%b busy=%b ready=%b want 0 0 0", wr_en, busy, byte_ready);
        else pass_cnt++;
        step(); step(); step();
        total_cnt++;
        if (wa_q.size() !== 1 || wa_q[0] !== 64'd0)
            $display("FAIL abort4th_writes: writes=%0d want 1 at addr 0", wa_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_toggle_valid();
        test_len_bounds();
        test_abort_partial();
        test_reset_mid();
        test_busy_start_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
